// File: rtl/carregador_programa.sv
// SAP-1 program loader: streams 16 bytes into RAM, then releases the CPU
// and watches n_hlt, with an optional execute-cycle watchdog.
module carregador_programa #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int MAX_CICLOS = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_n_we,
    output logic              run,
    output logic              cpu_n_clr,
    input  logic              n_hlt,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ADDR_W:0]   count,
    output logic [15:0]       ciclos
);

    typedef enum logic [2:0] {
        OCIOSO,
        RECEBE,
        ESCREVE,
        SEGURA,
        LIBERA,
        EXECUTA,
        PARADO
    } estado_t;

    localparam logic [ADDR_W-1:0] ULTIMO = '1;
    localparam bit                WD_ON  = (MAX_CICLOS != 0);
    // Only meaningful when the watchdog is enabled.
    localparam logic [15:0]       LIMITE = 16'(MAX_CICLOS - 1);

    estado_t           estado;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       prox_ciclos;

    always_comb begin
        prox_ciclos = ciclos;
        if (ciclos != 16'hFFFF) prox_ciclos = ciclos + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            estado    <= OCIOSO;
            addr      <= '0;
            in_ready  <= 1'b0;
            mem_n_we  <= 1'b1;
            run       <= 1'b0;
            cpu_n_clr <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            count     <= '0;
            ciclos    <= '0;
            mem_a     <= '0;
            mem_d     <= '0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (start) begin
                        estado   <= RECEBE;
                        busy     <= 1'b1;
                        addr     <= '0;
                        count    <= '0;
                        in_ready <= 1'b1;
                    end
                end
                RECEBE: begin
                    if (in_valid && in_ready) begin
                        mem_d    <= in_data;
                        mem_a    <= addr;
                        in_ready <= 1'b0;
                        mem_n_we <= 1'b0;
                        estado   <= ESCREVE;
                    end
                end
                ESCREVE: begin
                    mem_n_we <= 1'b1;
                    estado   <= SEGURA;
                end
                SEGURA: begin
                    count <= count + (ADDR_W+1)'(1);
                    if (addr == ULTIMO) begin
                        run    <= 1'b1;
                        estado <= LIBERA;
                    end else begin
                        addr     <= addr + ADDR_W'(1);
                        in_ready <= 1'b1;
                        estado   <= RECEBE;
                    end
                end
                LIBERA: begin
                    cpu_n_clr <= 1'b1;
                    estado    <= EXECUTA;
                end
                EXECUTA: begin
                    ciclos <= prox_ciclos;
                    // Halt beats a watchdog expiry on the same cycle.
                    if (!n_hlt) begin
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        estado <= PARADO;
                    end else if (WD_ON && ciclos == LIMITE) begin
                        timeout   <= 1'b1;
                        cpu_n_clr <= 1'b0;
                        busy      <= 1'b0;
                        estado    <= PARADO;
                    end
                end
                PARADO: begin
                    if (start) begin
                        run       <= 1'b0;
                        cpu_n_clr <= 1'b0;
                        done      <= 1'b0;
                        timeout   <= 1'b0;
                        count     <= '0;
                        ciclos    <= '0;
                        addr      <= '0;
                        busy      <= 1'b1;
                        in_ready  <= 1'b1;
                        estado    <= RECEBE;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Bench for carregador_programa: two instances (no watchdog / watchdog 8)
// checked each cycle against a transaction-level model plus literal checks.
module tb_carregador_programa;

    logic       clk = 1'b0;
    logic       clr, start, in_valid, n_hlt;
    logic [7:0] in_data;

    logic       in_ready  [2];
    logic [3:0] mem_a     [2];
    logic [7:0] mem_d     [2];
    logic       mem_n_we  [2];
    logic       run       [2];
    logic       cpu_n_clr [2];
    logic       busy      [2];
    logic       done      [2];
    logic       timeout   [2];
    logic [4:0] count     [2];
    logic [15:0] ciclos   [2];

    int n_chk = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int ir_cnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    carregador_programa #(.ADDR_W(4), .DATA_W(8), .MAX_CICLOS(0)) dut0 (
        .clk(clk), .clr(clr), .start(start),
        .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
        .mem_a(mem_a[0]), .mem_d(mem_d[0]), .mem_n_we(mem_n_we[0]),
        .run(run[0]), .cpu_n_clr(cpu_n_clr[0]), .n_hlt(n_hlt),
        .busy(busy[0]), .done(done[0]), .timeout(timeout[0]),
        .count(count[0]), .ciclos(ciclos[0])
    );

    carregador_programa #(.ADDR_W(4), .DATA_W(8), .MAX_CICLOS(8)) dut1 (
        .clk(clk), .clr(clr), .start(start),
        .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
        .mem_a(mem_a[1]), .mem_d(mem_d[1]), .mem_n_we(mem_n_we[1]),
        .run(run[1]), .cpu_n_clr(cpu_n_clr[1]), .n_hlt(n_hlt),
        .busy(busy[1]), .done(done[1]), .timeout(timeout[1]),
        .count(count[1]), .ciclos(ciclos[1])
    );

    // Model: md 0 idle, 1 loading, 2 release, 3 running, 4 stopped.
    // ph is the loading sub-step: 0 waiting, 1 strobing, 2 holding.
    typedef struct {
        int         md;
        int         ph;
        int         nb;
        logic [3:0] wa;
        logic [7:0] wd;
        int         cy;
        bit         dn;
        bit         to;
    } m_t;

    m_t m [2];

    function automatic m_t step(m_t s, int mx);
        m_t n = s;
        if (clr) begin
            n.md = 0; n.ph = 0; n.nb = 0; n.wa = '0; n.wd = '0;
            n.cy = 0; n.dn = 1'b0; n.to = 1'b0;
        end else begin
            case (s.md)
                0: if (start) begin n.md = 1; n.ph = 0; n.nb = 0; end
                1: begin
                    if (s.ph == 0) begin
                        if (in_valid) begin
                            n.wa = 4'(s.nb); n.wd = in_data; n.ph = 1;
                        end
                    end else if (s.ph == 1) begin
                        n.ph = 2;
                    end else begin
                        n.nb = s.nb + 1;
                        if (n.nb == 16) n.md = 2;
                        else n.ph = 0;
                    end
                end
                2: n.md = 3;
                3: begin
                    n.cy = (s.cy < 65535) ? s.cy + 1 : s.cy;
                    if (!n_hlt) begin
                        n.md = 4; n.dn = 1'b1;
                    end else if (mx != 0 && s.cy == mx - 1) begin
                        n.md = 4; n.to = 1'b1;
                    end
                end
                4: if (start) begin
                    n.md = 1; n.ph = 0; n.nb = 0; n.cy = 0;
                    n.dn = 1'b0; n.to = 1'b0;
                end
                default: n.md = 0;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m[0] <= step(m[0], 0);
        m[1] <= step(m[1], 8);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("in_ready%0d", k), int'(in_ready[k]),
                    int'(m[k].md == 1 && m[k].ph == 0));
                chk($sformatf("mem_n_we%0d", k), int'(mem_n_we[k]),
                    int'(!(m[k].md == 1 && m[k].ph == 1)));
                chk($sformatf("mem_a%0d", k), int'(mem_a[k]), int'(m[k].wa));
                chk($sformatf("mem_d%0d", k), int'(mem_d[k]), int'(m[k].wd));
                chk($sformatf("run%0d", k), int'(run[k]), int'(m[k].md >= 2));
                chk($sformatf("cpu_n_clr%0d", k), int'(cpu_n_clr[k]),
                    int'(m[k].md == 3 || (m[k].md == 4 && !m[k].to)));
                chk($sformatf("busy%0d", k), int'(busy[k]),
                    int'(m[k].md >= 1 && m[k].md <= 3));
                chk($sformatf("done%0d", k), int'(done[k]), int'(m[k].dn));
                chk($sformatf("timeout%0d", k), int'(timeout[k]), int'(m[k].to));
                chk($sformatf("count%0d", k), int'(count[k]), m[k].nb);
                chk($sformatf("ciclos%0d", k), int'(ciclos[k]), m[k].cy);
            end
            if (!mem_n_we[0]) we_cnt++;
            if (in_ready[0]) ir_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        bit r;
        int n;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        r = 1'b0;
        while (!r && n < 50) begin
            @(negedge clk);
            r = in_ready[0];
            @(posedge clk);
            #1;
            n++;
        end
        chk("handshake_bound", int'(r), 1);
    endtask

    logic [7:0] prog [16];
    logic [7:0] nw   [16];
    logic [7:0] bp   [5];

    initial begin
        for (int i = 0; i < 16; i++) begin
            prog[i] = 8'h00;
            nw[i]   = 8'(i * 17 + 3);
        end
        prog[0] = 8'h09; prog[1] = 8'h1A; prog[2] = 8'h2B;
        prog[3] = 8'hE0; prog[4] = 8'hF0;
        bp[0] = 8'h11; bp[1] = 8'h22; bp[2] = 8'h33;
        bp[3] = 8'h44; bp[4] = 8'h55;

        clr = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_data = 8'h00; n_hlt = 1'b1;

        // Reset with inputs toggling
        tick();
        chk_en = 1'b1;
        start = 1'b1; in_valid = 1'b1; n_hlt = 1'b0;
        tick();
        clr = 1'b0; start = 1'b0; in_valid = 1'b0; n_hlt = 1'b1;
        sample();
        chk("rst_in_ready", int'(in_ready[0]), 0);
        chk("rst_mem_n_we", int'(mem_n_we[0]), 1);
        chk("rst_run", int'(run[0]), 0);
        chk("rst_cpu_n_clr", int'(cpu_n_clr[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_done_to", int'({done[0], timeout[0]}), 0);
        chk("rst_count", int'(count[0]), 0);
        chk("rst_ciclos", int'(ciclos[0]), 0);

        // Full load with in_valid held high
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        we_cnt = 0; ir_cnt = 0;
        for (int i = 0; i < 16; i++) send_byte(prog[i], 0);
        sample();
        chk("last_we", int'(mem_n_we[0]), 0);
        chk("last_a", int'(mem_a[0]), 15);
        tick(); sample();
        chk("segura_run", int'(run[0]), 0);
        tick(); sample();
        chk("libera_run", int'(run[0]), 1);
        chk("libera_nclr", int'(cpu_n_clr[0]), 0);
        chk("load_count", int'(count[0]), 16);
        chk("load_we_pulses", we_cnt, 16);
        chk("load_ready_cycles", ir_cnt, 16);
        in_valid = 1'b0;
        tick(); sample();
        chk("exec_nclr", int'(cpu_n_clr[0]), 1);

        // Halt on execute cycle 40; start on cycle 5 is ignored
        for (int c = 2; c <= 40; c++) begin
            tick();
            start = (c == 5);
            n_hlt = (c != 40);
        end
        tick();
        n_hlt = 1'b1;
        sample();
        chk("halt_done", int'(done[0]), 1);
        chk("halt_busy", int'(busy[0]), 0);
        chk("halt_ciclos", int'(ciclos[0]), 40);
        chk("halt_nclr", int'(cpu_n_clr[0]), 1);
        chk("wd_timeout", int'(timeout[1]), 1);
        chk("wd_done", int'(done[1]), 0);
        chk("wd_nclr", int'(cpu_n_clr[1]), 0);
        chk("wd_ciclos", int'(ciclos[1]), 8);

        // Restart from PARADO
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        sample();
        chk("restart_run", int'(run[0]), 0);
        chk("restart_nclr", int'(cpu_n_clr[0]), 0);
        chk("restart_ciclos", int'(ciclos[0]), 0);
        chk("restart_wd_to", int'(timeout[1]), 0);

        // Backpressure: valid on every 4th cycle
        we_cnt = 0;
        for (int i = 0; i < 5; i++) send_byte(bp[i], 3);
        in_valid = 1'b0;
        tick(); tick(); sample();
        chk("bp_count", int'(count[0]), 5);
        chk("bp_we_pulses", we_cnt, 5);
        chk("bp_last_d", int'(mem_d[0]), 8'h55);

        // Abort during the strobe of byte 5
        clr = 1'b1;
        tick();
        clr = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h60 + i), 0);
        in_valid = 1'b0;
        sample();
        chk("abort_we_before", int'(mem_n_we[0]), 0);
        chk("abort_a_before", int'(mem_a[0]), 4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        sample();
        chk("abort_we", int'(mem_n_we[0]), 1);
        chk("abort_count", int'(count[0]), 0);
        chk("abort_busy", int'(busy[0]), 0);

        // Reload from scratch, then halt on cycle 8 (beats watchdog)
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(nw[0], 0);
        sample();
        chk("reload_a0", int'(mem_a[0]), 0);
        chk("reload_d0", int'(mem_d[0]), 8'h03);
        for (int i = 1; i < 16; i++) send_byte(nw[i], 0);
        in_valid = 1'b0;
        tick(); tick(); tick();
        for (int c = 1; c <= 8; c++) begin
            n_hlt = (c != 8);
            tick();
        end
        n_hlt = 1'b1;
        sample();
        chk("tie_done", int'(done[1]), 1);
        chk("tie_timeout", int'(timeout[1]), 0);
        chk("tie_ciclos", int'(ciclos[1]), 8);
        chk("tie_nclr", int'(cpu_n_clr[1]), 1);
        chk("tie_done0", int'(done[0]), 1);

        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired, want finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "time limit");
    end

endmodule
